seg_display_scanner: RTL and testbench
======================================

// Module: seg_display_scanner
// PURPOSE
//  Time-multiplexed 7-segment display driver; consumes the divided scan clock from the
//  flip-flop-chain clock divider (level signal in the 100 MHz clock domain).
//  Each scan_clock rising edge advances to the next digit. A blanking gap between digits
//  suppresses ghosting. Outputs go straight to board anode/segment pins.
// PARAMETERS
//  NUM_DIGITS       4   digits scanned; 2..8
//  BLANK_CYCLES     16  clock cycles with all anodes off between digits; >=1
//  ANODE_ACTIVE_LOW 1   1: anode pin driven 0 = digit on
//  SEG_ACTIVE_LOW   1   1: segment/dp pin driven 0 = lit
// PORTS
//  clock        in   1              100 MHz system clock; the only clock
//  reset        in   1              synchronous, active-high
//  scan_clock   in   1              divided clock level from the divider; edge-detected here
//  value        in   4*NUM_DIGITS   hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost
//  digit_enable in   NUM_DIGITS     1 = digit k may light; 0 = slot kept dark
//  dp_in        in   NUM_DIGITS     decimal point request per digit
//  anode        out  NUM_DIGITS     digit select, polarity per ANODE_ACTIVE_LOW
//  segment      out  7              {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  dp_out       out  1              decimal point, polarity per SEG_ACTIVE_LOW
//  digit_index  out  clog2(NUM_DIGITS)  digit currently selected (debug/verification)
// BEHAVIOUR
//  - One clock (clock); reset is synchronous and active-high. All outputs are registered.
//  - Reset: state=BLANK, blank counter=0, digit_index=0, scan_q=1.
//    Reset: anode all inactive, segment all unlit, dp_out unlit.
//    With defaults: anode=4'b1111, segment=7'h7F, dp_out=1.
//  - Edge detect: scan_edge = scan_clock & ~scan_q; scan_q <= scan_clock every clock.
//    scan_q resets to 1, so a high scan_clock at reset release is not an edge.
//  - FSM BLANK:
//      anodes inactive; segment/dp unlit; counter increments each cycle.
//      When counter==BLANK_CYCLES-1: clear counter, go to DRIVE.
//      Snapshot value nibble, dp_in bit and digit_enable bit for digit_index.
//      The DRIVE outputs load on that same edge.
//      BLANK therefore lasts exactly BLANK_CYCLES cycles.
//  - FSM DRIVE:
//      anode[digit_index] active iff snapshot enable = 1; all other anodes inactive.
//      segment = decoded snapshot nibble; dp_out = snapshot dp.
//      If the snapshot enable is 0: segment and dp_out unlit.
//      On scan_edge: digit_index <= (digit_index==NUM_DIGITS-1) ? 0 : digit_index+1; go to BLANK.
//      Outputs go dark on the same edge.
//  - scan_edge during BLANK: ignored (dropped, not queued).
//    Index advances at most once per DRIVE period.
//  - value/dp_in/digit_enable changes during DRIVE: no effect until the next BLANK->DRIVE snapshot.
//  - Reset mid-DRIVE or mid-BLANK: next edge returns to the reset state.
//    The scan restarts at digit 0 after a full BLANK.
//  - Decode (active-high form, before polarity):
//      0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//      8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//  - Polarity inversion is applied after decode and after the blank/enable gating.
// STRUCTURE
//  - Shared header seg_defs.vh (`include):
//      hex-to-segment constant table; SEG_OFF_AH=7'h00; FSM state encodings BLANK=1'b0, DRIVE=1'b1.
//  - Sub-module hex_to_7seg: combinational, 4-bit in, 7-bit active-high out; shared by other display blocks.
//  - Top: edge detector, blank counter, state register, digit index, snapshot registers, output registers.
// TESTING (NUM_DIGITS=4, BLANK_CYCLES=4, both polarities active-low)
//  1. Reset held 3 cycles while scan_clock toggles.
//     -> anode=4'b1111, segment=7'h7F, dp_out=1, digit_index=0 throughout.
//  2. Release reset with value=16'h1234, enable=4'b1111, dp_in=0.
//     -> 4 cycles dark, then anode=4'b1110, segment=7'h19 (digit "4").
//  3. scan_clock rising edge -> 4 cycles dark, then anode=4'b1101, segment=7'h30 ("3").
//     After 4 edges total, digit_index wraps to 0 and anode=4'b1110.
//  4. digit_enable=4'b1011, dp_in=4'b0001.
//     -> digit 2 slot stays anode=1111, seg=7F with the same timing.
//     -> dp_out=0 only while digit 0 is driven.
//  5. value changed to 16'h0000 mid-DRIVE of digit 0.
//     -> segment stays 7'h19 until the next DRIVE of digit 0, which shows 7'h40.
//  6. Extra scan edge inside BLANK -> index advances once only.
//     Reset pulse mid-DRIVE -> dark next cycle, index=0, restart after 4 blank cycles.

Source files
------------

// File: rtl/seg_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_scanner_pkg
//   Shared definitions for the 7-segment scanner.
//   - state_t     : scanner FSM state (BLANK = all dark, DRIVE = one digit lit)
//   - SEG_OFF_AH  : active-high "all segments off" pattern
//   - hex_seg()   : hex nibble -> active-high {g,f,e,d,c,b,a} pattern
// -----------------------------------------------------------------------------
package seg_display_scanner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF_AH = 7'h00;

  function automatic logic [6:0] hex_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_display_scanner_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
//   Combinational hex-to-7-segment decoder, active-high output.
//   Ports:
//     i_hex  in  4  hex nibble
//     o_seg  out 7  {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module hex_to_7seg
  import seg_display_scanner_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = hex_seg(i_hex);
  end

endmodule

// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//   Time-multiplexed 7-segment display driver. Each rising edge of the divided
//   scan_clock level moves on to the next digit; every digit is preceded by a
//   BLANK_CYCLES-long all-dark gap to suppress ghosting. All outputs registered.
//   Ports:
//     clock         in   1            system clock
//     reset         in   1            synchronous, active-high
//     scan_clock    in   1            divided scan level (edge-detected here)
//     value         in   4*NUM_DIGITS hex nibbles, digit 0 = value[3:0]
//     digit_enable  in   NUM_DIGITS   1 = digit may light
//     dp_in         in   NUM_DIGITS   decimal point request per digit
//     anode         out  NUM_DIGITS   digit select (polarity ANODE_ACTIVE_LOW)
//     segment       out  7            {g,f,e,d,c,b,a} (polarity SEG_ACTIVE_LOW)
//     dp_out        out  1            decimal point (polarity SEG_ACTIVE_LOW)
//     digit_index   out  IW           digit currently selected
//     dbg_state     out  state_t      FSM state, for observation only
// -----------------------------------------------------------------------------
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int BLANK_CYCLES     = 16,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    scan_clock,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_enable,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp_out,
  output logic [IW-1:0]           digit_index,
  output state_t                  dbg_state
);

  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_scan_q;
  logic [3:0]      r_snap_nib;
  logic            r_snap_en;
  logic            r_snap_dp;

  logic            w_scan_edge;
  logic [3:0]      w_nib;
  logic            w_en;
  logic            w_dp;
  logic [6:0]      w_seg_ah;
  logic [NUM_DIGITS-1:0] w_anode_ah;
  logic [NUM_DIGITS-1:0] w_anode_pin;
  logic [6:0]      w_seg_pin;
  logic            w_dp_pin;
  logic [NUM_DIGITS-1:0] w_anode_dark;
  logic [6:0]      w_seg_dark;
  logic            w_dp_dark;

  // r_scan_q resets high so a scan level already high at reset release is
  // not mistaken for a fresh edge.
  assign w_scan_edge = scan_clock & ~r_scan_q;

  // In BLANK the decoder looks at the live inputs so the DRIVE outputs can be
  // loaded on the very edge that leaves BLANK; in DRIVE it re-decodes the
  // snapshot, so input changes mid-DRIVE have no effect.
  always_comb begin
    if (r_state == ST_BLANK) begin
      w_nib = value[int'(digit_index)*4 +: 4];
      w_en  = digit_enable[digit_index];
      w_dp  = dp_in[digit_index];
    end else begin
      w_nib = r_snap_nib;
      w_en  = r_snap_en;
      w_dp  = r_snap_dp;
    end
  end

  hex_to_7seg u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg_ah)
  );

  // Gating by enable first, polarity last.
  assign w_anode_ah   = w_en ? (NUM_DIGITS'(1) << digit_index) : '0;
  assign w_anode_pin  = ANODE_ACTIVE_LOW ? ~w_anode_ah : w_anode_ah;
  assign w_seg_pin    = SEG_ACTIVE_LOW ? ~(w_en ? w_seg_ah : SEG_OFF_AH)
                                       :  (w_en ? w_seg_ah : SEG_OFF_AH);
  assign w_dp_pin     = SEG_ACTIVE_LOW ? ~(w_en & w_dp) : (w_en & w_dp);
  assign w_anode_dark = ANODE_ACTIVE_LOW ? '1 : '0;
  assign w_seg_dark   = SEG_ACTIVE_LOW ? ~SEG_OFF_AH : SEG_OFF_AH;
  assign w_dp_dark    = SEG_ACTIVE_LOW;

  assign dbg_state = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_BLANK;
      r_cnt       <= '0;
      r_scan_q    <= 1'b1;
      digit_index <= '0;
      r_snap_nib  <= '0;
      r_snap_en   <= 1'b0;
      r_snap_dp   <= 1'b0;
      anode       <= w_anode_dark;
      segment     <= w_seg_dark;
      dp_out      <= w_dp_dark;
    end else begin
      r_scan_q <= scan_clock;
      case (r_state)
        ST_BLANK: begin
          // Scan edges arriving here are dropped on purpose.
          if (r_cnt == LAST_CNT) begin
            r_cnt      <= '0;
            r_state    <= ST_DRIVE;
            r_snap_nib <= w_nib;
            r_snap_en  <= w_en;
            r_snap_dp  <= w_dp;
            anode      <= w_anode_pin;
            segment    <= w_seg_pin;
            dp_out     <= w_dp_pin;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            anode   <= w_anode_dark;
            segment <= w_seg_dark;
            dp_out  <= w_dp_dark;
          end
        end
        default: begin
          if (w_scan_edge) begin
            digit_index <= (digit_index == LAST_IDX) ? '0 : digit_index + 1'b1;
            r_state     <= ST_BLANK;
            anode       <= w_anode_dark;
            segment     <= w_seg_dark;
            dp_out      <= w_dp_dark;
          end else begin
            anode   <= w_anode_pin;
            segment <= w_seg_pin;
            dp_out  <= w_dp_pin;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//   Directed steps followed by a random phase, all checked every cycle against
//   a reference model that tracks "cycles of darkness left" and "digit shown".
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

  localparam int ND = 4;
  localparam int BC = 4;

  // clock / reset block
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          scan_clock   = 1'b0;
  logic [15:0]   value        = '0;
  logic [ND-1:0] digit_enable = '0;
  logic [ND-1:0] dp_in        = '0;
  logic [ND-1:0] anode;
  logic [6:0]    segment;
  logic          dp_out;
  logic [1:0]    digit_index;
  logic          dbg_state;

  seg_display_scanner #(
    .NUM_DIGITS       (ND),
    .BLANK_CYCLES     (BC),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .scan_clock   (scan_clock),
    .value        (value),
    .digit_enable (digit_enable),
    .dp_in        (dp_in),
    .anode        (anode),
    .segment      (segment),
    .dp_out       (dp_out),
    .digit_index  (digit_index),
    .dbg_state    (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model
  int         m_dark_left = BC;
  int         m_idx       = 0;
  logic       m_prev      = 1'b1;
  logic [3:0] m_anode     = 4'hF;
  logic [6:0] m_seg       = 7'h7F;
  logic       m_dp        = 1'b1;

  task automatic show_dark();
    m_anode = 4'hF;
    m_seg   = 7'h7F;
    m_dp    = 1'b1;
  endtask

  task automatic show_digit();
    logic       en;
    logic [3:0] nib;
    logic [3:0] one;
    en  = digit_enable[m_idx];
    nib = 4'((value >> (4 * m_idx)) & 16'hF);
    one = 4'(1 << m_idx);
    m_anode = en ? ~one : 4'hF;
    m_seg   = en ? ~seg_tab[nib] : 7'h7F;
    m_dp    = ~(en & dp_in[m_idx]);
  endtask

  task automatic model_clock();
    logic edge_seen;
    if (reset) begin
      m_prev      = 1'b1;
      m_dark_left = BC;
      m_idx       = 0;
      show_dark();
    end else begin
      edge_seen = scan_clock & ~m_prev;
      m_prev    = scan_clock;
      if (m_dark_left > 0) begin
        m_dark_left--;
        if (m_dark_left == 0) show_digit();
      end else if (edge_seen) begin
        m_idx       = (m_idx + 1) % ND;
        m_dark_left = BC;
        show_dark();
      end
    end
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("anode",       32'(anode),       32'(m_anode));
    chk("segment",     32'(segment),     32'(m_seg));
    chk("dp_out",      32'(dp_out),      32'(m_dp));
    chk("digit_index", 32'(digit_index), 32'(m_idx));
    chk("state",       32'(dbg_state),   32'(m_dark_left == 0));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic scan_pulse();
    scan_clock = 1'b1;
    step();
    scan_clock = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    // 1: reset held while scan_clock toggles
    for (int i = 0; i < 3; i++) begin
      scan_clock = ~scan_clock;
      step();
    end
    chk("t1_anode", 32'(anode), 32'h0F);
    chk("t1_seg",   32'(segment), 32'h7F);

    // 2: release; dark for BC cycles, then digit 0 shows "4"
    reset        = 1'b0;
    scan_clock   = 1'b0;
    value        = 16'h1234;
    digit_enable = 4'b1111;
    dp_in        = 4'b0000;
    repeat (BC - 1) step();
    chk("t2_dark", 32'(anode), 32'h0F);
    step();
    chk("t2_anode", 32'(anode), 32'b1110);
    chk("t2_seg",   32'(segment), 32'h19);
    repeat (3) step();

    // 3: scan through all digits, wrap to 0
    scan_pulse();
    chk("t3_anode", 32'(anode), 32'b1101);
    chk("t3_seg",   32'(segment), 32'h30);
    repeat (3) scan_pulse();
    chk("t3_wrap_idx",   32'(digit_index), 32'd0);
    chk("t3_wrap_anode", 32'(anode), 32'b1110);

    // 4: digit 2 disabled, dp on digit 0
    digit_enable = 4'b1011;
    dp_in        = 4'b0001;
    repeat (4) scan_pulse();
    chk("t4_dp_d0", 32'(dp_out), 32'd0);
    scan_pulse();
    chk("t4_dp_d1", 32'(dp_out), 32'd1);
    scan_pulse();
    chk("t4_d2_anode", 32'(anode), 32'hF);
    chk("t4_d2_seg",   32'(segment), 32'h7F);
    repeat (2) scan_pulse();

    // 5: value change mid-DRIVE of digit 0 is not visible until re-snapshot
    value = 16'h0000;
    repeat (3) step();
    chk("t5_hold", 32'(segment), 32'h19);
    repeat (4) scan_pulse();
    chk("t5_new", 32'(segment), 32'h40);

    // 6: extra edge inside BLANK is dropped; reset mid-DRIVE restarts
    scan_clock = 1'b1; step();
    scan_clock = 1'b0; step();
    scan_clock = 1'b1; step();
    scan_clock = 1'b0;
    repeat (6) step();
    chk("t6_once", 32'(digit_index), 32'd1);
    reset = 1'b1; step();
    chk("t6_rst_anode", 32'(anode), 32'hF);
    chk("t6_rst_idx",   32'(digit_index), 32'd0);
    reset = 1'b0;
    repeat (BC) step();
    chk("t6_restart", 32'(anode), 32'b1110);

    // random phase
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0)   scan_clock   = ~scan_clock;
      if ($urandom_range(0, 19) == 0)  value        = 16'($urandom);
      if ($urandom_range(0, 29) == 0)  digit_enable = 4'($urandom);
      if ($urandom_range(0, 29) == 0)  dp_in        = 4'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
